// File: rtl/pipelinedefs.sv
// Shared pipeline widths and the aux-result queue entry layout.
package pipelinedefs;
    localparam int WIDTH = 32;
    localparam int RA_W  = 5;

    typedef struct packed {
        logic            live;
        logic [RA_W-1:0] rdst;
        logic [WIDTH-1:0] data;
    } wbarb_entry;
endpackage

// File: rtl/wbarb_fifo.sv
// Aux result queue with parallel kill-by-destination.
// Optional WBARB_PENDING_EN adds live-destination lookups for decode.
module wbarb_fifo
    import pipelinedefs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wbarb_entry            push_entry,
    input  logic                  pop,
    input  logic                  kill,
    input  logic [RA_W-1:0]       kill_rdst,
    output wbarb_entry            head,
    output logic [$clog2(DEPTH):0] cnt,
    output logic                  any_live
`ifdef WBARB_PENDING_EN
    ,
    input  logic [RA_W-1:0]       chk_rs1,
    input  logic [RA_W-1:0]       chk_rs2,
    output logic                  pend_rs1,
    output logic                  pend_rs2
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wbarb_entry    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    assign head = mem[rd_ptr];

    always_comb begin
        any_live = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].live) any_live = 1'b1;
        end
    end

    // Popped slots lose their live bit so live always implies occupied.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && mem[i].rdst == kill_rdst) mem[i].live <= 1'b0;
            end
            if (pop) begin
                mem[rd_ptr].live <= 1'b0;
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr <= wr_ptr + 1'b1;
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

`ifdef WBARB_PENDING_EN
    always_comb begin
        pend_rs1 = push && push_entry.live && push_entry.rdst == chk_rs1;
        pend_rs2 = push && push_entry.live && push_entry.rdst == chk_rs2;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].live && mem[i].rdst == chk_rs1) pend_rs1 = 1'b1;
            if (mem[i].live && mem[i].rdst == chk_rs2) pend_rs2 = 1'b1;
        end
        if (chk_rs1 == '0) pend_rs1 = 1'b0;
        if (chk_rs2 == '0) pend_rs2 = 1'b0;
    end
`endif
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback vs queued aux results.
// Optional WBARB_PENDING_EN adds pending-destination lookups for decode.
module wb_port_arbiter
    import pipelinedefs::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wb_we,
    input  logic [RA_W-1:0]        i_wb_rdst,
    input  logic [WIDTH-1:0]       i_wb_data,
    output logic                   o_pipe_stall,
    input  logic                   i_aux_valid,
    input  logic [RA_W-1:0]        i_aux_rdst,
    input  logic [WIDTH-1:0]       i_aux_data,
    output logic                   o_aux_ready,
    output logic                   o_rf_we,
    output logic [RA_W-1:0]        o_rf_addr,
    output logic [WIDTH-1:0]       o_rf_data,
    output logic [$clog2(DEPTH):0] o_fifo_cnt
`ifdef WBARB_PENDING_EN
    ,
    input  logic [RA_W-1:0]        i_chk_rs1,
    input  logic [RA_W-1:0]        i_chk_rs2,
    output logic                   o_pend_rs1,
    output logic                   o_pend_rs2
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    wbarb_entry    head;
    wbarb_entry    push_entry;
    logic          any_live;
    logic          head_live;
    logic          head_dead;
    logic          pipe_req;
    logic          force_aux;
    logic          grant_aux;
    logic          grant_pipe;
    logic          push;
    logic          pop;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;

    // Producers are held off while in reset.
    assign o_aux_ready = rst && (o_fifo_cnt < CW'(DEPTH));
    assign push        = i_aux_valid && o_aux_ready;
    assign push_entry  = '{live: (i_aux_rdst != '0),
                           rdst: i_aux_rdst,
                           data: i_aux_data};

    assign head_live  = (o_fifo_cnt != '0) && head.live;
    assign head_dead  = (o_fifo_cnt != '0) && !head.live;
    assign pipe_req   = i_wb_we && (i_wb_rdst != '0);
    assign force_aux  = head_live && (starve_q == SW'(STARVE_MAX));
    assign grant_aux  = force_aux || (!pipe_req && head_live);
    assign grant_pipe = !force_aux && pipe_req;
    assign pop        = grant_aux || head_dead;

    assign o_pipe_stall = force_aux;

    always_comb begin
        starve_d = starve_q;
        if (grant_aux) begin
            starve_d = '0;
        end else if (grant_pipe && head_live) begin
            if (starve_q != SW'(STARVE_MAX)) starve_d = starve_q + 1'b1;
        end else if (!any_live) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q  <= '0;
            o_rf_we   <= 1'b0;
            o_rf_addr <= '0;
            o_rf_data <= '0;
        end else begin
            starve_q <= starve_d;
            o_rf_we  <= grant_aux || grant_pipe;
            if (grant_aux) begin
                o_rf_addr <= head.rdst;
                o_rf_data <= head.data;
            end else if (grant_pipe) begin
                o_rf_addr <= i_wb_rdst;
                o_rf_data <= i_wb_data;
            end
        end
    end

    // A pipeline write is younger than every queued entry to the same register.
    wbarb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .kill      (grant_pipe),
        .kill_rdst (i_wb_rdst),
        .head      (head),
        .cnt       (o_fifo_cnt),
        .any_live  (any_live)
`ifdef WBARB_PENDING_EN
        ,
        .chk_rs1   (i_chk_rs1),
        .chk_rs2   (i_chk_rs2),
        .pend_rs1  (o_pend_rs1),
        .pend_rs2  (o_pend_rs2)
`endif
    );
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table, corner sequences, random vs queue model.
// Honours WBARB_PENDING_EN when defined.
module tb_wb_port_arbiter;
    import pipelinedefs::*;

    localparam int DEPTH = 4;
    localparam int SMAX  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic             wb_we;
    logic [RA_W-1:0]  wb_rdst;
    logic [WIDTH-1:0] wb_data;
    logic             pipe_stall;
    logic             aux_valid;
    logic [RA_W-1:0]  aux_rdst;
    logic [WIDTH-1:0] aux_data;
    logic             aux_ready;
    logic             rf_we;
    logic [RA_W-1:0]  rf_addr;
    logic [WIDTH-1:0] rf_data;
    logic [2:0]       fifo_cnt;
`ifdef WBARB_PENDING_EN
    logic [RA_W-1:0]  chk_rs1;
    logic [RA_W-1:0]  chk_rs2;
    logic             pend_rs1;
    logic             pend_rs2;
`endif

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_wb_we     (wb_we),
        .i_wb_rdst   (wb_rdst),
        .i_wb_data   (wb_data),
        .o_pipe_stall(pipe_stall),
        .i_aux_valid (aux_valid),
        .i_aux_rdst  (aux_rdst),
        .i_aux_data  (aux_data),
        .o_aux_ready (aux_ready),
        .o_rf_we     (rf_we),
        .o_rf_addr   (rf_addr),
        .o_rf_data   (rf_data),
        .o_fifo_cnt  (fifo_cnt)
`ifdef WBARB_PENDING_EN
        ,
        .i_chk_rs1   (chk_rs1),
        .i_chk_rs2   (chk_rs2),
        .o_pend_rs1  (pend_rs1),
        .o_pend_rs2  (pend_rs2)
`endif
    );

    int checks = 0;
    int errors = 0;

    wbarb_entry       q[$];
    int               starve;
    logic             m_we;
    logic [RA_W-1:0]  m_addr;
    logic [WIDTH-1:0] m_data;
    logic             s_stall;
    logic             s_ready;

    typedef struct packed {
        logic             wb_we;
        logic [4:0]       wb_rdst;
        logic [31:0]      wb_data;
        logic             av;
        logic [4:0]       ar;
        logic [31:0]      ad;
        logic             stall;
        logic             ready;
        logic             we;
        logic [4:0]       addr;
        logic [31:0]      data;
        logic [2:0]       cnt;
    } vec_t;

    vec_t tv [15];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    task automatic model_reset();
        q.delete();
        starve = 0;
        m_we   = 1'b0;
    endtask

`ifdef WBARB_PENDING_EN
    function automatic bit pend_ref(logic [RA_W-1:0] rs, bit pushing);
        bit h;
        h = pushing && aux_rdst == rs;
        foreach (q[i]) if (q[i].live && q[i].rdst == rs) h = 1'b1;
        return h && rs != '0;
    endfunction
`endif

    // Inputs are already driven; checks one full clock against the queue model.
    task automatic cycle();
        bit hl, hd, anyl, frc, preq, pushing, gaux, gpipe;
        wbarb_entry e;
        #1;
        hl   = q.size() > 0 && q[0].live;
        hd   = q.size() > 0 && !q[0].live;
        anyl = 1'b0;
        foreach (q[i]) if (q[i].live) anyl = 1'b1;
        frc     = hl && starve == SMAX;
        preq    = wb_we && wb_rdst != '0;
        pushing = aux_valid && q.size() < DEPTH;
        s_stall = pipe_stall;
        s_ready = aux_ready;
        chk("stall", pipe_stall, frc);
        chk("ready", aux_ready, q.size() < DEPTH);
`ifdef WBARB_PENDING_EN
        chk("pend_rs1", pend_rs1, pend_ref(chk_rs1, pushing));
        chk("pend_rs2", pend_rs2, pend_ref(chk_rs2, pushing));
`endif
        gaux  = frc || (!preq && hl);
        gpipe = !frc && preq;
        m_we  = gaux || gpipe;
        if (gaux) begin
            m_addr = q[0].rdst;
            m_data = q[0].data;
        end else if (gpipe) begin
            m_addr = wb_rdst;
            m_data = wb_data;
        end
        if (gaux) starve = 0;
        else if (gpipe && hl) starve = (starve < SMAX) ? starve + 1 : SMAX;
        else if (!anyl) starve = 0;
        if (gpipe) foreach (q[i]) if (q[i].rdst == wb_rdst) q[i].live = 1'b0;
        if (gaux || hd) void'(q.pop_front());
        if (pushing) begin
            e.live = aux_rdst != '0;
            e.rdst = aux_rdst;
            e.data = aux_data;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("rf_we", rf_we, m_we);
        if (m_we) begin
            chk("rf_addr", rf_addr, m_addr);
            chk("rf_data", rf_data, m_data);
        end
        chk("fifo_cnt", fifo_cnt, q.size());
    endtask

    task automatic drive(logic we, int rd, logic [31:0] d, logic av, int ar, logic [31:0] ad);
        wb_we     = we;
        wb_rdst   = RA_W'(rd);
        wb_data   = d;
        aux_valid = av;
        aux_rdst  = RA_W'(ar);
        aux_data  = ad;
    endtask

    initial begin
        bit hold;
        drive(0, 0, 0, 0, 0, 0);
`ifdef WBARB_PENDING_EN
        chk_rs1 = '0;
        chk_rs2 = '0;
`endif
        model_reset();

        tv[0]  = '{0, 0, 0,     1, 5, 'hA5, 0, 1, 0, 0, 0,     1};
        tv[1]  = '{0, 0, 0,     0, 0, 0,    0, 1, 1, 5, 'hA5,  0};
        tv[2]  = '{1, 3, 'h30,  1, 7, 'h77, 0, 1, 1, 3, 'h30,  1};
        tv[3]  = '{1, 3, 'h31,  0, 0, 0,    0, 1, 1, 3, 'h31,  1};
        tv[4]  = '{1, 3, 'h32,  0, 0, 0,    0, 1, 1, 3, 'h32,  1};
        tv[5]  = '{1, 3, 'h33,  0, 0, 0,    0, 1, 1, 3, 'h33,  1};
        tv[6]  = '{1, 3, 'h34,  0, 0, 0,    1, 1, 1, 7, 'h77,  0};
        tv[7]  = '{1, 3, 'h34,  0, 0, 0,    0, 1, 1, 3, 'h34,  0};
        tv[8]  = '{1, 3, 'h35,  0, 0, 0,    0, 1, 1, 3, 'h35,  0};
        tv[9]  = '{1, 3, 'h36,  1, 9, 'h11, 0, 1, 1, 3, 'h36,  1};
        tv[10] = '{1, 9, 'h22,  0, 0, 0,    0, 1, 1, 9, 'h22,  1};
        tv[11] = '{0, 0, 0,     0, 0, 0,    0, 1, 0, 0, 0,     0};
        tv[12] = '{0, 0, 0,     0, 0, 0,    0, 1, 0, 0, 0,     0};
        tv[13] = '{1, 0, 'h66,  1, 0, 'h55, 0, 1, 0, 0, 0,     1};
        tv[14] = '{0, 0, 0,     0, 0, 0,    0, 1, 0, 0, 0,     0};

        #2;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_rf_data", rf_data, 0);
        chk("rst_cnt", fifo_cnt, 0);
        chk("rst_stall", pipe_stall, 0);
        chk("rst_ready", aux_ready, 0);
        #20;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 15; k++) begin
            drive(tv[k].wb_we, tv[k].wb_rdst, tv[k].wb_data,
                  tv[k].av, tv[k].ar, tv[k].ad);
            cycle();
            chk($sformatf("tv%0d_stall", k), s_stall, tv[k].stall);
            chk($sformatf("tv%0d_ready", k), s_ready, tv[k].ready);
            chk($sformatf("tv%0d_we", k), rf_we, tv[k].we);
            if (tv[k].we) begin
                chk($sformatf("tv%0d_addr", k), rf_addr, tv[k].addr);
                chk($sformatf("tv%0d_data", k), rf_data, tv[k].data);
            end
            chk($sformatf("tv%0d_cnt", k), fifo_cnt, tv[k].cnt);
        end

        for (int j = 0; j < 4; j++) begin
            drive(1, 1, 32'h100 + j, 1, 10 + j, 32'hA0 + j);
            cycle();
        end
        chk("full_cnt", fifo_cnt, 4);
        drive(1, 1, 32'h140, 1, 14, 32'hAE);
        cycle();
        chk("full_ready", s_ready, 0);
        chk("full_stall", s_stall, 1);
        chk("full_aux_addr", rf_addr, 10);
        cycle();
        chk("ready_back", s_ready, 1);
        chk("held_pipe_addr", rf_addr, 1);
        drive(0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 6; j++) cycle();

`ifdef WBARB_PENDING_EN
        chk_rs1 = 5'd4;
        chk_rs2 = 5'd6;
`endif
        for (int j = 0; j < 3; j++) begin
            drive(1, 1, 32'h200 + j, 1, 4 + j, 32'hB0 + j);
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("pre_rst_cnt", fifo_cnt, 3);
        chk("pre_rst_we", rf_we, 1);
`ifdef WBARB_PENDING_EN
        chk("pre_rst_pend", pend_rs1, 1);
`endif
        rst = 1'b0;
        #1;
        chk("mid_rst_we", rf_we, 0);
        chk("mid_rst_addr", rf_addr, 0);
        chk("mid_rst_data", rf_data, 0);
        chk("mid_rst_cnt", fifo_cnt, 0);
        chk("mid_rst_ready", aux_ready, 0);
        chk("mid_rst_stall", pipe_stall, 0);
`ifdef WBARB_PENDING_EN
        chk("mid_rst_pend1", pend_rs1, 0);
        chk("mid_rst_pend2", pend_rs2, 0);
`endif
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int j = 0; j < 4; j++) cycle();

        hold = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if (!hold) begin
                wb_we   = ($urandom_range(0, 3) != 0);
                wb_rdst = RA_W'($urandom_range(0, 7));
                wb_data = $urandom;
            end
            aux_valid = ($urandom_range(0, 2) != 0);
            aux_rdst  = RA_W'($urandom_range(0, 7));
            aux_data  = $urandom;
`ifdef WBARB_PENDING_EN
            chk_rs1 = RA_W'($urandom_range(0, 7));
            chk_rs2 = RA_W'($urandom_range(0, 7));
`endif
            cycle();
            hold = s_stall;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
